// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: rebuilds x/y/video_on from hsync/vsync, measures line/frame totals, tracks lock.
// Optional macro VGA_RX_SYNC2FF_EN adds a 2-flop synchronizer on hsync/vsync ahead of edge detection.
module vga_timing_receiver #(
   parameter int HD          = 640,
   parameter int VD          = 480,
   parameter int HTOTAL      = 800,
   parameter int VTOTAL      = 525,
   parameter int H_SYNC_X    = 656,
   parameter int V_SYNC_Y    = 513,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        hsync,
   input  logic        vsync,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        video_on,
   output logic        locked,
   output logic        frame_start,
   output logic        lock_lost,
   output logic [10:0] h_total_meas,
   output logic [10:0] v_total_meas,
   output logic [7:0]  err_cnt
);

   localparam logic [10:0] CNT_MAX = 11'd2047;
   localparam logic [9:0]  X_LAST  = 10'(HTOTAL - 1);
   localparam logic [9:0]  Y_LAST  = 10'(VTOTAL - 1);
   localparam logic [9:0]  X_LOAD  = 10'(H_SYNC_X);
   localparam logic [9:0]  Y_LOAD  = 10'(V_SYNC_Y);
   localparam logic [9:0]  X_VIS   = 10'(HD);
   localparam logic [9:0]  Y_VIS   = 10'(VD);
   localparam logic [10:0] H_EXP   = 11'(HTOTAL);
   localparam logic [10:0] V_EXP   = 11'(VTOTAL);
   localparam logic [4:0]  LOCK_N  = 5'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   logic hs_in, vs_in;

`ifdef VGA_RX_SYNC2FF_EN
   logic [1:0] hs_sync_q, vs_sync_q;

   // Synchronizers run every clock, independent of p_tick.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         hs_sync_q <= '0;
         vs_sync_q <= '0;
      end else begin
         hs_sync_q <= {hs_sync_q[0], hsync};
         vs_sync_q <= {vs_sync_q[0], vsync};
      end
   end

   assign hs_in = hs_sync_q[1];
   assign vs_in = vs_sync_q[1];
`else
   assign hs_in = hsync;
   assign vs_in = vsync;
`endif

   state_t      state_q, state_d;
   logic        hs_q, hs_d, vs_q, vs_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [10:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
   logic        h_valid_q, h_valid_d, frame_bad_q, frame_bad_d;
   logic [3:0]  good_q, good_d;
   logic [7:0]  err_q, err_d;
   logic        fs_q, fs_d, lost_q, lost_d;

   logic        hs_rise, vs_rise, x_wrap, line_err, total_bad, frame_bad;
   logic [10:0] h_meas_new, lcnt_close;

   // Event decode; a line arriving on the vsync tick is folded into the closing frame.
   always_comb begin
      hs_rise    = p_tick & hs_in & ~hs_q;
      vs_rise    = p_tick & vs_in & ~vs_q;
      x_wrap     = p_tick & ~hs_rise & (x_q == X_LAST);
      h_meas_new = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
      lcnt_close = (hs_rise && (lcnt_q != CNT_MAX)) ? lcnt_q + 11'd1 : lcnt_q;
      line_err   = (hs_rise & h_valid_q & (h_meas_new != H_EXP))
                 | (p_tick & ~hs_rise & (hcnt_q == CNT_MAX - 11'd1));
      total_bad  = (lcnt_close != V_EXP);
      frame_bad  = frame_bad_q | line_err | total_bad;
   end

   // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
   always_comb begin
      hs_d        = hs_q;
      vs_d        = vs_q;
      x_d         = x_q;
      y_d         = y_q;
      hcnt_d      = hcnt_q;
      lcnt_d      = lcnt_q;
      h_meas_d    = h_meas_q;
      v_meas_d    = v_meas_q;
      h_valid_d   = h_valid_q;
      frame_bad_d = frame_bad_q;
      if (p_tick) begin
         hs_d = hs_in;
         vs_d = vs_in;
         if (hs_rise) begin
            x_d       = X_LOAD;
            hcnt_d    = '0;
            h_meas_d  = h_meas_new;
            h_valid_d = 1'b1;
         end else begin
            x_d = x_wrap ? '0 : x_q + 10'd1;
            if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 11'd1;
         end
         if (vs_rise) begin
            y_d         = Y_LOAD;
            lcnt_d      = '0;
            v_meas_d    = lcnt_close;
            frame_bad_d = 1'b0;
         end else begin
            if (x_wrap) y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
            lcnt_d      = lcnt_close;
            frame_bad_d = frame_bad_q | line_err;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = err_q;
      lost_d  = 1'b0;
      fs_d    = (state_q == LOCKED) & x_wrap & ~vs_rise & (y_q == Y_LAST);
      case (state_q)
         SEARCH: begin
            if (vs_rise) begin
               state_d = MEASURE;
               good_d  = '0;
            end
         end
         MEASURE: begin
            if (vs_rise) begin
               if (frame_bad) begin
                  good_d = '0;
               end else if ((5'(good_q) + 5'd1) >= LOCK_N) begin
                  state_d = LOCKED;
                  good_d  = '0;
               end else begin
                  good_d = good_q + 4'd1;
               end
            end
         end
         LOCKED: begin
            // Any bad line drops lock at once; the frame total is only known at vsync.
            if (line_err || (vs_rise && total_bad)) begin
               state_d = SEARCH;
               good_d  = '0;
               lost_d  = 1'b1;
               err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q     <= SEARCH;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         hcnt_q      <= '0;
         lcnt_q      <= '0;
         h_meas_q    <= '0;
         v_meas_q    <= '0;
         h_valid_q   <= 1'b0;
         frame_bad_q <= 1'b0;
         good_q      <= '0;
         err_q       <= '0;
         fs_q        <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         x_q         <= x_d;
         y_q         <= y_d;
         hcnt_q      <= hcnt_d;
         lcnt_q      <= lcnt_d;
         h_meas_q    <= h_meas_d;
         v_meas_q    <= v_meas_d;
         h_valid_q   <= h_valid_d;
         frame_bad_q <= frame_bad_d;
         good_q      <= good_d;
         err_q       <= err_d;
         fs_q        <= fs_d;
         lost_q      <= lost_d;
      end
   end

   assign x            = x_q;
   assign y            = y_q;
   assign locked       = (state_q == LOCKED);
   assign video_on     = locked & (x_q < X_VIS) & (y_q < Y_VIS);
   assign frame_start  = fs_q;
   assign lock_lost    = lost_q;
   assign h_total_meas = h_meas_q;
   assign v_total_meas = v_meas_q;
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Self-checking bench for vga_timing_receiver, run with a scaled-down raster so whole frames fit in a short run.
module tb_vga_timing_receiver;

   localparam int HD  = 16;
   localparam int VD  = 10;
   localparam int HT  = 24;
   localparam int VT  = 16;
   localparam int HSX = 18;
   localparam int HSW = 3;
   localparam int VSY = 12;

   logic        clk_100MHz = 1'b0;
   logic        reset, p_tick, hsync, vsync;
   logic [9:0]  x, y;
   logic        video_on, locked, frame_start, lock_lost;
   logic [10:0] h_total_meas, v_total_meas;
   logic [7:0]  err_cnt;

   vga_timing_receiver #(
      .HD(HD), .VD(VD), .HTOTAL(HT), .VTOTAL(VT),
      .H_SYNC_X(HSX), .V_SYNC_Y(VSY), .LOCK_FRAMES(2)
   ) dut (
      .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .video_on(video_on), .locked(locked), .frame_start(frame_start),
      .lock_lost(lock_lost), .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
      .err_cnt(err_cnt)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   int n_checks = 0;
   int n_fail   = 0;

   // Generator-side view of the sync stream, used to predict the measurements.
   bit m_hs_prev, m_vs_prev, m_h_seen;
   int m_hticks, m_lines;
   int h_q[$];
   int v_q[$];

   int  lost_cnt = 0, lost_on_hs = 0, lost_wide = 0;
   bit  lost_prev;
   int  vid_acc, fs_acc;

   task automatic model_clear();
      m_hs_prev = 0; m_vs_prev = 0; m_h_seen = 0;
      m_hticks  = 0; m_lines   = 0;
      h_q.delete(); v_q.delete();
      lost_prev = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_100MHz);
      reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
      repeat (3) @(negedge clk_100MHz);
      reset = 1'b0;
      model_clear();
   endtask

   // One clock: drive inputs, predict, then sample one half-period after the active edge.
   task automatic clk_step(input logic p, input logic hs, input logic vs,
                           input bit chk, input int ex, input int ey);
      bit hr, vr;
      int e;
      hr = 0; vr = 0;
      p_tick = p; hsync = hs; vsync = vs;
      if (p) begin
         hr = hs && !m_hs_prev;
         vr = vs && !m_vs_prev;
         m_hs_prev = hs; m_vs_prev = vs;
         m_hticks++;
         if (hr) begin
            if (m_h_seen) h_q.push_back((m_hticks > 2047) ? 2047 : m_hticks);
            m_h_seen = 1; m_hticks = 0; m_lines++;
         end
         if (vr) begin
            v_q.push_back((m_lines > 2047) ? 2047 : m_lines);
            m_lines = 0;
         end
      end
      @(negedge clk_100MHz);
      if (hr && h_q.size() > 0) begin
         e = h_q.pop_front();
         n_checks++;
         if (h_total_meas !== 11'(e)) begin
            n_fail++;
            $display("FAIL h_total_meas: got %0d expected %0d at %0t", h_total_meas, e, $time);
         end
      end
      if (vr && v_q.size() > 0) begin
         e = v_q.pop_front();
         n_checks++;
         if (v_total_meas !== 11'(e)) begin
            n_fail++;
            $display("FAIL v_total_meas: got %0d expected %0d at %0t", v_total_meas, e, $time);
         end
      end
      if (chk) begin
         n_checks++;
         if (x !== 10'(ex) || y !== 10'(ey)) begin
            n_fail++;
            $display("FAIL xy_track: got x=%0d y=%0d expected x=%0d y=%0d at %0t", x, y, ex, ey, $time);
         end
      end
      if (lock_lost === 1'b1) begin
         lost_cnt++;
         if (hr) lost_on_hs++;
         if (lost_prev) lost_wide++;
      end
      lost_prev = (lock_lost === 1'b1);
      if (video_on === 1'b1) vid_acc++;
      if (frame_start === 1'b1) fs_acc++;
   endtask

   // Frame starts on the vsync rising line; vsync covers the first two lines.
   task automatic send_frame(input int nlines, input int short_idx, input int short_len,
                             input int exp_lock, input int abort_after, input int div);
      int  t, len;
      bit  chk;
      logic hs, vs;
      t = 0;
      chk = (exp_lock == 1) && (short_idx < 0) && (nlines == VT);
      vid_acc = 0; fs_acc = 0;
      for (int r = 0; r < nlines; r++) begin
         len = (r == short_idx) ? short_len : HT;
         for (int gx = 0; gx < len; gx++) begin
            if (abort_after > 0 && t == abort_after) return;
            hs = (gx >= HSX) && (gx < HSX + HSW);
            vs = (r < 2);
            clk_step(1'b1, hs, vs, chk, gx, (VSY + r) % VT);
            if (t == 0) begin
               n_checks++;
               if (locked !== 1'(exp_lock)) begin
                  n_fail++;
                  $display("FAIL locked_at_vs: got %0b expected %0d at %0t", locked, exp_lock, $time);
               end
            end
            for (int k = 1; k < div; k++) clk_step(1'b0, hs, vs, chk, gx, (VSY + r) % VT);
            t++;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk_100MHz);
      reset = 1'b1; p_tick = 1'b1; hsync = 1'b1; vsync = 1'b1;
      repeat (2) @(negedge clk_100MHz);
      n_checks++;
      if ({x, y, video_on, locked, frame_start, lock_lost, h_total_meas, v_total_meas, err_cnt} !== 54'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: x=%0d y=%0d vo=%0b lk=%0b fs=%0b ll=%0b h=%0d v=%0d err=%0d expected all 0",
                  x, y, video_on, locked, frame_start, lock_lost, h_total_meas, v_total_meas, err_cnt);
      end
      do_reset();
   endtask

   task automatic test_nominal();
      do_reset();
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
      n_checks++;
      if (vid_acc != HD * VD) begin
         n_fail++;
         $display("FAIL nominal_video_on: got %0d ticks expected %0d", vid_acc, HD * VD);
      end
      n_checks++;
      if (fs_acc != 1) begin
         n_fail++;
         $display("FAIL nominal_frame_start: got %0d pulses expected 1", fs_acc);
      end
      n_checks++;
      if (err_cnt !== 8'd0 || lost_cnt != 0 || h_total_meas !== 11'(HT) || v_total_meas !== 11'(VT)) begin
         n_fail++;
         $display("FAIL nominal_status: err=%0d lost=%0d h=%0d v=%0d expected 0 0 %0d %0d",
                  err_cnt, lost_cnt, h_total_meas, v_total_meas, HT, VT);
      end
   endtask

   task automatic test_short_line();
      int base_lost, base_hs;
      base_lost = lost_cnt; base_hs = lost_on_hs;
      send_frame(VT, 5, HT - 1, 1, 0, 1);
      n_checks++;
      if (lost_cnt != base_lost + 1 || lost_on_hs != base_hs + 1 || lost_wide != 0) begin
         n_fail++;
         $display("FAIL short_lock_lost: pulses=%0d on_hs=%0d wide=%0d expected 1 1 0",
                  lost_cnt - base_lost, lost_on_hs - base_hs, lost_wide);
      end
      n_checks++;
      if (locked !== 1'b0 || err_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL short_status: locked=%0b err=%0d expected 0 1", locked, err_cnt);
      end
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
   endtask

   task automatic test_timeout();
      int base_lost;
      base_lost = lost_cnt;
      for (int i = 0; i < 2100; i++) clk_step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if (locked !== 1'b0 || lost_cnt != base_lost + 1 || lost_wide != 0 || err_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL timeout_drop: locked=%0b pulses=%0d wide=%0d err=%0d expected 0 1 0 2",
                  locked, lost_cnt - base_lost, lost_wide, err_cnt);
      end
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
   endtask

   task automatic test_reset_mid();
      send_frame(VT, -1, HT, 1, 200, 1);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({x, y, video_on, locked, frame_start, lock_lost, h_total_meas, v_total_meas, err_cnt} !== 54'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: x=%0d y=%0d lk=%0b h=%0d v=%0d err=%0d expected all 0",
                  x, y, locked, h_total_meas, v_total_meas, err_cnt);
      end
      p_tick = 1'b1; hsync = 1'b1; vsync = 1'b1;
      repeat (3) @(negedge clk_100MHz);
      n_checks++;
      if ({x, y, video_on, locked, frame_start, lock_lost, h_total_meas, v_total_meas, err_cnt} !== 54'd0) begin
         n_fail++;
         $display("FAIL reset_mid_hold: x=%0d y=%0d lk=%0b h=%0d v=%0d err=%0d expected all 0",
                  x, y, locked, h_total_meas, v_total_meas, err_cnt);
      end
      p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
      reset = 1'b0;
      model_clear();
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 0, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
      send_frame(VT, -1, HT, 1, 0, 1);
      n_checks++;
      if (vid_acc != HD * VD || err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_relock: video=%0d err=%0d expected %0d 0", vid_acc, err_cnt, HD * VD);
      end
   endtask

   task automatic test_short_frame();
      do_reset();
      send_frame(VT,     -1, HT, 0, 0, 1);
      send_frame(VT - 1, -1, HT, 0, 0, 1);
      send_frame(VT,     -1, HT, 0, 0, 1);
      send_frame(VT,     -1, HT, 0, 0, 1);
      send_frame(VT,     -1, HT, 1, 0, 1);
      n_checks++;
      if (err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL short_frame_err: got %0d expected 0", err_cnt);
      end
   endtask

   task automatic test_slow_tick();
      do_reset();
      send_frame(VT, -1, HT, 0, 0, 4);
      send_frame(VT, -1, HT, 0, 0, 4);
      send_frame(VT, -1, HT, 1, 0, 4);
      send_frame(VT, -1, HT, 1, 0, 4);
      n_checks++;
      if (vid_acc != 4 * HD * VD || fs_acc != 1) begin
         n_fail++;
         $display("FAIL slow_video: video=%0d fs=%0d expected %0d 1", vid_acc, fs_acc, 4 * HD * VD);
      end
      n_checks++;
      if (err_cnt !== 8'd0 || h_total_meas !== 11'(HT) || v_total_meas !== 11'(VT) || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL slow_status: err=%0d h=%0d v=%0d lk=%0b expected 0 %0d %0d 1",
                  err_cnt, h_total_meas, v_total_meas, locked, HT, VT);
      end
   endtask

   initial begin
      reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
      model_clear();
      test_reset();
      test_nominal();
      test_short_line();
      test_timeout();
      test_reset_mid();
      test_short_frame();
      test_slow_tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
